sm83_irq_ctl: RTL and testbench
===============================

Name: sm83_irq_ctl

Overview:
- Interrupt controller sitting on the responder side of the CPU core's irq/iack handshake and external memory bus.
- Latches peripheral interrupt events into IF (0xFF0F) and holds the enable mask IE (0xFFFF); both are CPU-readable and CPU-writable.
- Drives the core's irq vector with pending-and-enabled bits.
- Clears the acknowledged bit when the core returns a one-hot iack.

Parameters:
- NUM_IRQS, 8, width of the irq/iack vectors and of IE.
- NUM_SRC, 5, number of implemented request sources (VBlank, STAT, timer, serial, joypad); IF bits at and above NUM_SRC are unimplemented.
- IF_ADR, 16'hFF0F, bus address of the IF register.
- IE_ADR, 16'hFFFF, bus address of the IE register.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- adr  in  16  CPU address bus.
- din  in  8  CPU write data (core's dout).
- dout  out  8  read data to CPU (core's din).
- dout_oe  out  1  this block drives dout for the current read.
- rd  in  1  CPU read strobe, active high (core's p_rd).
- wr  in  1  CPU write strobe, active high (core's p_wr).
- src  in  NUM_SRC  peripheral request levels; a rising edge requests an interrupt.
- irq  out  NUM_IRQS  pending and enabled interrupts to the core.
- iack  in  NUM_IRQS  one-hot acknowledge from the core.
- dbg_if  out  8  IF register value as read by the CPU.
- dbg_ie  out  8  IE register value.

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - IF=0, IE=0, irq=0, dout_oe=0.
  - wr_q=1; src_q=all ones, so sources held high across reset produce no event.
- Source edge detect:
  - src_q registers src every cycle.
  - rise = src & ~src_q, one-cycle pulse; this is the only way hardware sets IF.
- Write detect:
  - wr_q registers wr every cycle.
  - Commit happens on the clk edge where wr=1 and wr_q=0.
  - adr and din are sampled on that same edge.
  - A held wr strobe commits exactly once.
- IF next-state, per implemented bit i<NUM_SRC, applied in this order:
  1. base = IF write commit ? din[i] : IF[i].
  2. base &= ~iack[i].
  3. IF[i] = base | rise[i].
- IF precedence:
  - A new event always wins over a same-cycle acknowledge or CPU clear.
  - An acknowledge wins over a same-cycle CPU set.
- Unimplemented IF bits: stored as 0 and read as 1.
- IE: full 8-bit register, written on an IE write commit; iack does not affect it.
- irq: combinational, irq = {3'b0, IF[NUM_SRC-1:0]} & IE.
  - A request rising at edge N is visible on irq after edge N.
  - An iack presented before edge N removes the bit after edge N.
- iack: not one-hot (0 or multiple bits) is legal; every set bit clears its IF bit.
- Read path: combinational.
  - dout_oe = rd & (adr==IF_ADR | adr==IE_ADR).
  - dout = IF view {1,1,1,IF[4:0]} or IE.
  - dout = 8'hFF when not selected.
  - Reads have no side effects.
- Reset mid-operation: reset dominates all same-cycle writes, events and acknowledges.
- Address map: any address other than IF_ADR/IE_ADR is ignored for both reads and writes.

Decomposition:
- Shared package sm83_pkg holds:
  - word_t / irq_t typedefs;
  - the IRQ bit-index constants IRQ_VBLANK=0, IRQ_STAT=1, IRQ_TIMER=2, IRQ_SERIAL=3, IRQ_JOYPAD=4;
  - the IF_ADR/IE_ADR defaults.
- One sub-module: sm83_edge_det (parameterised width, reset-to-ones, rising-pulse output), instanced for src and for wr.

Test Plan:
- Reset with src=5'b00001 held, then release -> IF=0, irq=0, dbg_if reads 8'hE0.
- IE write 8'h05 (commit on wr rising edge); src[0] pulses 0->1 -> after that edge irq=8'h01; read 0xFF0F gives dout=8'hE1, dout_oe=1.
- iack=8'h01 for one cycle -> IF[0]=0 and irq=8'h00 after the edge; keep wr high for 4 cycles on an IF write of 8'h1F -> exactly one commit, and IF=8'h1F read back as 8'hFF.
- Same cycle as iack=8'h04, src[2] rises -> IF[2] stays 1 and irq[2] stays 1 (given IE[2]=1).
- CPU writes IF=8'h00 in the same cycle that src[3] rises -> IF=8'h08; CPU writes IF=8'h02 with iack=8'h02 -> IF[1]=0.
- Read at 0xFF10 -> dout_oe=0, dout=8'hFF; assert reset during an IF write of 8'h1F with src[4] rising -> IF=0, IE=0.

Source files
------------

// File: rtl/sm83_irq_ctl_pkg.sv
// Shared SM83 types, interrupt bit indices and register address defaults.
package sm83_pkg;

  typedef logic [7:0]  word_t;
  typedef logic [7:0]  irq_t;
  typedef logic [15:0] addr_t;

  // Bit positions of the implemented request sources in IF/IE/irq.
  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  // Memory-mapped register addresses.
  localparam addr_t IF_ADR_DEF = 16'hFF0F;
  localparam addr_t IE_ADR_DEF = 16'hFFFF;

endpackage

// File: rtl/sm83_irq_ctl_if.sv
// CPU-side bus plus irq/iack handshake between the core and the interrupt controller.
interface sm83_irq_ctl_if;
  import sm83_pkg::*;

  addr_t adr;
  word_t din;
  word_t dout;
  logic  dout_oe;
  logic  rd;
  logic  wr;
  irq_t  irq;
  irq_t  iack;

  // Core side: drives the bus and acknowledges interrupts.
  modport master (
    output adr, din, rd, wr, iack,
    input  dout, dout_oe, irq
  );

  // Controller side: answers reads and raises interrupts.
  modport slave (
    input  adr, din, rd, wr, iack,
    output dout, dout_oe, irq
  );
endinterface

// File: rtl/sm83_irq_ctl_edge_det.sv
// Rising-edge detector; history resets to ones so levels held across reset do not fire.
module sm83_edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sig,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev_q;
  logic [W-1:0] prev_d;

  // Next history value is simply the current input level.
  always_comb begin
    prev_d = sig;
  end

  // History register, preset to all ones on reset.
  always_ff @(posedge clk) begin
    if (reset) prev_q <= '1;
    else       prev_q <= prev_d;
  end

  assign rise = sig & ~prev_q;

endmodule

// File: rtl/sm83_irq_ctl.sv
// SM83 interrupt controller: IF/IE registers, request latching and acknowledge clearing.
module sm83_irq_ctl
  import sm83_pkg::*;
#(
  parameter int    NUM_IRQS = 8,
  parameter int    NUM_SRC  = 5,
  parameter addr_t IF_ADR   = IF_ADR_DEF,
  parameter addr_t IE_ADR   = IE_ADR_DEF
) (
  input  logic               clk,
  input  logic               reset,
  sm83_irq_ctl_if.slave      bus,
  input  logic [NUM_SRC-1:0] src,
  output word_t              dbg_if,
  output word_t              dbg_ie
);

  logic [NUM_SRC-1:0]  src_rise;
  logic                wr_rise;
  logic [NUM_SRC-1:0]  if_q;
  logic [NUM_SRC-1:0]  if_d;
  logic [NUM_IRQS-1:0] ie_q;
  logic [NUM_IRQS-1:0] ie_d;
  logic                if_wr;
  logic                ie_wr;
  logic                sel_if;
  logic                sel_ie;
  logic [NUM_IRQS-1:0] if_view;

  sm83_edge_det #(.W(NUM_SRC)) u_src_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (src),
    .rise  (src_rise)
  );

  // A held write strobe commits only on its first cycle.
  sm83_edge_det #(.W(1)) u_wr_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (bus.wr),
    .rise  (wr_rise)
  );

  // Decode register write commits.
  always_comb begin
    if_wr = wr_rise && (bus.adr == IF_ADR);
    ie_wr = wr_rise && (bus.adr == IE_ADR);
  end

  // IF next state: CPU write, then acknowledge clears, then new events win over both.
  always_comb begin
    if_d = if_wr ? bus.din[NUM_SRC-1:0] : if_q;
    if_d = if_d & ~bus.iack[NUM_SRC-1:0];
    if_d = if_d | src_rise;
  end

  // IE next state: only CPU writes touch it.
  always_comb begin
    ie_d = ie_wr ? bus.din[NUM_IRQS-1:0] : ie_q;
  end

  // Register state; reset overrides any same-cycle write, event or acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_q <= '0;
      ie_q <= '0;
    end else begin
      if_q <= if_d;
      ie_q <= ie_d;
    end
  end

  // Unimplemented IF bits read back as ones; the interrupt vector masks them off.
  always_comb begin
    if_view = {{(NUM_IRQS-NUM_SRC){1'b1}}, if_q};
    bus.irq = {{(NUM_IRQS-NUM_SRC){1'b0}}, if_q} & ie_q;
    dbg_if  = if_view;
    dbg_ie  = ie_q;
  end

  // Side-effect-free combinational read mux.
  always_comb begin
    sel_if      = bus.rd && (bus.adr == IF_ADR);
    sel_ie      = bus.rd && (bus.adr == IE_ADR);
    bus.dout_oe = sel_if || sel_ie;
    if (sel_if)      bus.dout = if_view;
    else if (sel_ie) bus.dout = ie_q;
    else             bus.dout = 8'hFF;
  end

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Self-checking bench for sm83_irq_ctl using an expected-value scoreboard queue.
module tb_sm83_irq_ctl;
  import sm83_pkg::*;

  typedef struct {
    string name;
    logic [7:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] src;
  word_t dbg_if;
  word_t dbg_ie;

  sm83_irq_ctl_if bus ();

  sm83_irq_ctl dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .src    (src),
    .dbg_if (dbg_if),
    .dbg_ie (dbg_ie)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t e;
  int   total  = 0;
  int   passed = 0;

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; src = 5'b00001;
    bus.adr = 16'h0000; bus.din = 8'h00; bus.rd = 1'b0; bus.wr = 1'b0; bus.iack = 8'h00;
    tick(); tick();
    reset = 1'b0;
    tick();
    sb.push_back('{"reset_dbg_if", 8'hE0});
    sb.push_back('{"reset_irq",    8'h00});
    sb.push_back('{"reset_dbg_ie", 8'h00});
    sb.push_back('{"reset_oe",     8'h00});
    e = sb.pop_front(); total++;
    if (dbg_if !== e.exp) $display("FAIL %s got %h want %h", e.name, dbg_if, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (bus.irq !== e.exp) $display("FAIL %s got %h want %h", e.name, bus.irq, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (dbg_ie !== e.exp) $display("FAIL %s got %h want %h", e.name, dbg_ie, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if ({7'd0, bus.dout_oe} !== e.exp) $display("FAIL %s got %h want %h", e.name, bus.dout_oe, e.exp); else passed++;
  endtask

  task automatic test_irq_raise();
    src = 5'b00000; tick();
    bus.adr = 16'hFFFF; bus.din = 8'h05; bus.wr = 1'b1; tick();
    bus.wr = 1'b0; tick();
    sb.push_back('{"ie_written", 8'h05});
    e = sb.pop_front(); total++;
    if (dbg_ie !== e.exp) $display("FAIL %s got %h want %h", e.name, dbg_ie, e.exp); else passed++;
    src = 5'b00001; tick();
    sb.push_back('{"vblank_irq", 8'h01});
    e = sb.pop_front(); total++;
    if (bus.irq !== e.exp) $display("FAIL %s got %h want %h", e.name, bus.irq, e.exp); else passed++;
    bus.rd = 1'b1; bus.adr = 16'hFF0F; #1;
    sb.push_back('{"rd_if_dout", 8'hE1});
    sb.push_back('{"rd_if_oe",   8'h01});
    e = sb.pop_front(); total++;
    if (bus.dout !== e.exp) $display("FAIL %s got %h want %h", e.name, bus.dout, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if ({7'd0, bus.dout_oe} !== e.exp) $display("FAIL %s got %h want %h", e.name, bus.dout_oe, e.exp); else passed++;
    bus.adr = 16'hFFFF; #1;
    sb.push_back('{"rd_ie_dout", 8'h05});
    e = sb.pop_front(); total++;
    if (bus.dout !== e.exp) $display("FAIL %s got %h want %h", e.name, bus.dout, e.exp); else passed++;
    bus.rd = 1'b0;
  endtask

  task automatic test_iack_and_held_write();
    bus.iack = 8'h01; tick();
    bus.iack = 8'h00;
    sb.push_back('{"iack_if",  8'hE0});
    sb.push_back('{"iack_irq", 8'h00});
    e = sb.pop_front(); total++;
    if (dbg_if !== e.exp) $display("FAIL %s got %h want %h", e.name, dbg_if, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (bus.irq !== e.exp) $display("FAIL %s got %h want %h", e.name, bus.irq, e.exp); else passed++;
    // Hold wr for four cycles; bit 0 is acked mid-hold and must not be rewritten.
    bus.adr = 16'hFF0F; bus.din = 8'h1F; bus.wr = 1'b1; tick();
    sb.push_back('{"held_wr_first", 8'hFF});
    e = sb.pop_front(); total++;
    if (dbg_if !== e.exp) $display("FAIL %s got %h want %h", e.name, dbg_if, e.exp); else passed++;
    bus.iack = 8'h01; tick();
    bus.iack = 8'h00; tick(); tick();
    bus.wr = 1'b0; tick();
    sb.push_back('{"held_wr_once", 8'hFE});
    sb.push_back('{"held_wr_irq",  8'h04});
    e = sb.pop_front(); total++;
    if (dbg_if !== e.exp) $display("FAIL %s got %h want %h", e.name, dbg_if, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (bus.irq !== e.exp) $display("FAIL %s got %h want %h", e.name, bus.irq, e.exp); else passed++;
  endtask

  task automatic test_event_vs_iack();
    src = 5'b00101; bus.iack = 8'h04; tick();
    bus.iack = 8'h00;
    sb.push_back('{"event_wins_if",  8'hFE});
    sb.push_back('{"event_wins_irq", 8'h04});
    e = sb.pop_front(); total++;
    if (dbg_if !== e.exp) $display("FAIL %s got %h want %h", e.name, dbg_if, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (bus.irq !== e.exp) $display("FAIL %s got %h want %h", e.name, bus.irq, e.exp); else passed++;
    bus.iack = 8'h04; tick();
    bus.iack = 8'h00;
    sb.push_back('{"iack_timer_if",  8'hFA});
    sb.push_back('{"iack_timer_irq", 8'h00});
    e = sb.pop_front(); total++;
    if (dbg_if !== e.exp) $display("FAIL %s got %h want %h", e.name, dbg_if, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (bus.irq !== e.exp) $display("FAIL %s got %h want %h", e.name, bus.irq, e.exp); else passed++;
  endtask

  task automatic test_cpu_vs_event();
    bus.adr = 16'hFF0F; bus.din = 8'h00; bus.wr = 1'b1; src = 5'b01101; tick();
    bus.wr = 1'b0;
    sb.push_back('{"clr_vs_event", 8'hE8});
    e = sb.pop_front(); total++;
    if (dbg_if !== e.exp) $display("FAIL %s got %h want %h", e.name, dbg_if, e.exp); else passed++;
    tick();
    bus.din = 8'h02; bus.wr = 1'b1; bus.iack = 8'h02; tick();
    bus.wr = 1'b0; bus.iack = 8'h00;
    sb.push_back('{"set_vs_iack", 8'hE0});
    e = sb.pop_front(); total++;
    if (dbg_if !== e.exp) $display("FAIL %s got %h want %h", e.name, dbg_if, e.exp); else passed++;
    tick();
  endtask

  task automatic test_unmapped_and_reset();
    bus.rd = 1'b1; bus.adr = 16'hFF10; #1;
    sb.push_back('{"unmapped_oe",   8'h00});
    sb.push_back('{"unmapped_dout", 8'hFF});
    e = sb.pop_front(); total++;
    if ({7'd0, bus.dout_oe} !== e.exp) $display("FAIL %s got %h want %h", e.name, bus.dout_oe, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (bus.dout !== e.exp) $display("FAIL %s got %h want %h", e.name, bus.dout, e.exp); else passed++;
    bus.rd = 1'b0; bus.din = 8'h1F; bus.wr = 1'b1; tick();
    bus.wr = 1'b0; tick();
    sb.push_back('{"unmapped_wr_if", 8'hE0});
    sb.push_back('{"unmapped_wr_ie", 8'h05});
    e = sb.pop_front(); total++;
    if (dbg_if !== e.exp) $display("FAIL %s got %h want %h", e.name, dbg_if, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (dbg_ie !== e.exp) $display("FAIL %s got %h want %h", e.name, dbg_ie, e.exp); else passed++;
    // Reset lands on the same edge as an IF write and a joypad event.
    bus.adr = 16'hFF0F; bus.din = 8'h1F; bus.wr = 1'b1; src = 5'b11101; reset = 1'b1; tick();
    sb.push_back('{"rst_mid_if",  8'hE0});
    sb.push_back('{"rst_mid_ie",  8'h00});
    sb.push_back('{"rst_mid_irq", 8'h00});
    e = sb.pop_front(); total++;
    if (dbg_if !== e.exp) $display("FAIL %s got %h want %h", e.name, dbg_if, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (dbg_ie !== e.exp) $display("FAIL %s got %h want %h", e.name, dbg_ie, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (bus.irq !== e.exp) $display("FAIL %s got %h want %h", e.name, bus.irq, e.exp); else passed++;
    // Releasing reset with wr and sources still high must not commit or latch.
    reset = 1'b0; tick();
    sb.push_back('{"post_rst_if", 8'hE0});
    e = sb.pop_front(); total++;
    if (dbg_if !== e.exp) $display("FAIL %s got %h want %h", e.name, dbg_if, e.exp); else passed++;
    bus.wr = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_irq_raise();
    test_iack_and_held_write();
    test_event_vs_iack();
    test_cpu_vs_event();
    test_unmapped_and_reset();
    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
